// File: rtl/data_mem_access_if.sv
// Load/store unit bundle: core-side request/response and
// data-memory bus between the core, the LSU and memory.
interface data_mem_access_if;
  logic        ls_start;
  logic        ls_wr;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_busy;
  logic        ls_done;
  logic        ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  ls_start, ls_wr, ls_funct3, ls_addr, ls_wdata,
    input  mem_ack, mem_rdata,
    output ls_busy, ls_done, ls_err, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output ls_start, ls_wr, ls_funct3, ls_addr, ls_wdata,
    output mem_ack, mem_rdata,
    input  ls_busy, ls_done, ls_err, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/data_mem_access.sv
// RV32 load/store unit: size/sign handling, lane steering,
// alignment check and timed single-beat data-memory access.
module data_mem_access #(
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  data_mem_access_if.slave bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          wr_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;

  logic [1:0]    sz;
  logic [1:0]    off;
  logic          f3_bad;
  logic          mis;
  logic          chk_err;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;
  logic [31:0]   sh;
  logic [7:0]    b;
  logic [15:0]   h;
  logic [31:0]   ext;

  // Request decode: legality, alignment and lane steering
  always_comb begin
    sz  = bus.ls_funct3[1:0];
    off = bus.ls_addr[1:0];
    if (bus.ls_wr)
      f3_bad = bus.ls_funct3[2] | (sz == 2'b11);
    else
      f3_bad = (sz == 2'b11) | (bus.ls_funct3 == 3'b110);
    mis = ((sz == 2'b01) & off[0])
        | ((sz == 2'b10) & (off != 2'b00));
    chk_err = f3_bad | mis;
    case (sz)
      2'b00:   be_n = 4'b0001 << off;
      2'b01:   be_n = 4'b0011 << off;
      default: be_n = 4'b1111;
    endcase
    case (sz)
      2'b00:   wd_n = {4{bus.ls_wdata[7:0]}};
      2'b01:   wd_n = {2{bus.ls_wdata[15:0]}};
      default: wd_n = bus.ls_wdata;
    endcase
  end

  // Load data extraction from the returned word
  always_comb begin
    sh = bus.mem_rdata >> {off_q, 3'b000};
    b  = sh[7:0];
    h  = off_q[1] ? bus.mem_rdata[31:16]
                  : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{b[7]}}, b};
      3'b001:  ext = {{16{h[15]}}, h};
      3'b100:  ext = {24'd0, b};
      3'b101:  ext = {16'd0, h};
      default: ext = bus.mem_rdata;
    endcase
  end

  // Control FSM, request latches and load result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ls_start) begin
            wr_q    <= bus.ls_wr;
            f3_q    <= bus.ls_funct3;
            off_q   <= off;
            we_q    <= bus.ls_wr;
            addr_q  <= {bus.ls_addr[31:2], 2'b00};
            be_q    <= be_n;
            wdata_q <= wd_n;
            cnt     <= '0;
            err_q   <= chk_err;
            state   <= chk_err ? S_DONE : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (bus.mem_ack) begin
            err_q <= 1'b0;
            state <= S_DONE;
            if (!wr_q)
              rdata_q <= ext;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ls_busy   = (state != S_IDLE);
  assign bus.ls_done   = (state == S_DONE);
  assign bus.ls_err    = (state == S_DONE) & err_q;
  assign bus.ls_rdata  = rdata_q;
  assign bus.mem_req   = (state == S_ACCESS);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Randomized bench for data_mem_access against an
// arithmetic model of RV32 load/store behaviour.
module tb_data_mem_access;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  data_mem_access_if bus();

  data_mem_access #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_rdata;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  function automatic bit illegal(input bit wr,
                                 input logic [2:0] f3,
                                 input logic [31:0] a);
    bit ok;
    if (wr) ok = (f3 inside {3'd0, 3'd1, 3'd2});
    else    ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!ok) return 1'b1;
    return (int'(a[1:0]) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] w);
    int off;
    longint bv;
    longint hv;
    off = int'(a[1:0]);
    bv = longint'((w >> (8 * off)) & 32'hFF);
    hv = longint'((w >> (16 * (off / 2))) & 32'hFFFF);
    case (f3)
      3'd0:    return 32'(bv >= 128 ? bv - 256 : bv);
      3'd1:    return 32'(hv >= 32768 ? hv - 65536 : hv);
      3'd4:    return 32'(bv);
      3'd5:    return 32'(hv);
      default: return w;
    endcase
  endfunction

  // d = wait cycles before ack, -1 = never ack
  task automatic do_txn(input bit wr,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input int d,
                        input logic [31:0] rd,
                        output int done_cyc);
    bit err;
    bit acked;
    int i;
    int n;
    int off;
    logic [3:0] ebe;
    logic [31:0] ewd;
    err = illegal(wr, f3, a);
    n = nbytes(f3);
    off = int'(a[1:0]);
    for (int j = 0; j < 4; j++) begin
      ebe[j] = (j >= off) && (j < off + n);
      ewd[8*j +: 8] = wd[8*(j % n) +: 8];
    end
    check("idle_busy", 32'(bus.ls_busy), 32'd0);
    bus.ls_start  = 1'b1;
    bus.ls_wr     = wr;
    bus.ls_funct3 = f3;
    bus.ls_addr   = a;
    bus.ls_wdata  = wd;
    bus.mem_ack   = 1'($urandom % 2);
    bus.mem_rdata = $urandom;
    step();
    bus.ls_addr  = $urandom;
    bus.ls_wdata = $urandom;
    i = 1;
    acked = 1'b0;
    if (!err) begin
      forever begin
        bus.ls_start = 1'($urandom % 2);
        check("mem_req", 32'(bus.mem_req), 32'd1);
        check("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
        check("mem_be", 32'(bus.mem_be), 32'(ebe));
        check("mem_we", 32'(bus.mem_we), 32'(wr));
        if (wr) check("mem_wdata", bus.mem_wdata, ewd);
        check("early_done", 32'(bus.ls_done), 32'd0);
        check("busy", 32'(bus.ls_busy), 32'd1);
        acked = (i == d + 1);
        bus.mem_ack   = acked;
        bus.mem_rdata = acked ? rd : $urandom;
        step();
        bus.ls_start  = 1'($urandom % 2);
        bus.mem_ack   = 1'($urandom % 2);
        bus.mem_rdata = $urandom;
        if (acked || i == TO) break;
        i++;
      end
      i++;
    end
    done_cyc = i;
    if (!err && acked && !wr) exp_rdata = load_val(f3, a, rd);
    check("done", 32'(bus.ls_done), 32'd1);
    check("err", 32'(bus.ls_err), 32'(err || !acked));
    check("done_req", 32'(bus.mem_req), 32'd0);
    check("rdata", bus.ls_rdata, exp_rdata);
    step();
    bus.ls_start = 1'b0;
    bus.mem_ack  = 1'($urandom % 2);
    check("done_pulse", 32'(bus.ls_done), 32'd0);
    check("back_idle", 32'(bus.ls_busy), 32'd0);
  endtask

  int dc;

  initial begin
    rst = 1'b1;
    bus.ls_start  = 1'b0;
    bus.ls_wr     = 1'b0;
    bus.ls_funct3 = 3'd0;
    bus.ls_addr   = 32'd0;
    bus.ls_wdata  = 32'd0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'd0;
    exp_rdata     = 32'd0;
    step();
    bus.ls_start = 1'b1;
    step();
    check("rst_busy", 32'(bus.ls_busy), 32'd0);
    check("rst_done", 32'(bus.ls_done), 32'd0);
    check("rst_err", 32'(bus.ls_err), 32'd0);
    check("rst_rdata", bus.ls_rdata, 32'd0);
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_be", 32'(bus.mem_be), 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    bus.ls_start = 1'b0;
    bus.mem_ack  = 1'b0;
    step();

    do_txn(1'b0, 3'd0, 32'h103, 32'd0, 2, 32'h80FF_1234, dc);
    check("lb_cyc", 32'(dc), 32'd4);
    check("lb_val", bus.ls_rdata, 32'hFFFF_FF80);
    do_txn(1'b0, 3'd5, 32'h202, 32'd0, 0, 32'hBEEF_0000, dc);
    check("lhu_cyc", 32'(dc), 32'd2);
    check("lhu_val", bus.ls_rdata, 32'h0000_BEEF);
    do_txn(1'b1, 3'd0, 32'h301, 32'hA5, 0, 32'h1111_1111, dc);
    check("sb_keep", bus.ls_rdata, 32'h0000_BEEF);
    do_txn(1'b0, 3'd2, 32'h402, 32'd0, 0, 32'd0, dc);
    check("lw_mis_cyc", 32'(dc), 32'd1);
    do_txn(1'b0, 3'd2, 32'h500, 32'd0, -1, 32'd0, dc);
    check("to_cyc", 32'(dc), 32'd16);
    do_txn(1'b0, 3'd2, 32'h504, 32'd0, 14, 32'hCAFE_F00D, dc);
    check("to_ack_cyc", 32'(dc), 32'd16);
    check("to_ack_val", bus.ls_rdata, 32'hCAFE_F00D);

    bus.ls_start  = 1'b1;
    bus.ls_wr     = 1'b0;
    bus.ls_funct3 = 3'd2;
    bus.ls_addr   = 32'h600;
    bus.mem_ack   = 1'b0;
    step();
    bus.ls_start = 1'b0;
    step();
    step();
    check("pre_rst_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    exp_rdata = 32'd0;
    check("ab_req", 32'(bus.mem_req), 32'd0);
    check("ab_done", 32'(bus.ls_done), 32'd0);
    check("ab_busy", 32'(bus.ls_busy), 32'd0);
    check("ab_rdata", bus.ls_rdata, 32'd0);
    check("ab_addr", bus.mem_addr, 32'd0);
    check("ab_be", 32'(bus.mem_be), 32'd0);
    step();
    bus.mem_ack = 1'b0;
    check("ab_idle_done", 32'(bus.ls_done), 32'd0);
    check("ab_idle_req", 32'(bus.mem_req), 32'd0);
    do_txn(1'b0, 3'd4, 32'h703, 32'd0, 1, 32'h7F00_0000, dc);
    check("post_rst_cyc", 32'(dc), 32'd3);
    check("post_rst_val", bus.ls_rdata, 32'h0000_007F);

    for (int k = 0; k < 200; k++) begin
      logic [31:0] ra;
      int rd_d;
      ra = $urandom;
      rd_d = int'($urandom_range(0, 16));
      if (rd_d == 16) rd_d = -1;
      do_txn(1'($urandom % 2), 3'($urandom % 8), ra,
             $urandom, rd_d, $urandom, dc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_access.md
DATA_MEM_ACCESS -- requirements
Module: data_mem_access

Interface
REQ-001 Parameter TIMEOUT, default 15, max cycles ACCESS waits for mem_ack before error.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ls_start  in  1  core request strobe, sampled only in IDLE.
REQ-005 ls_wr  in  1  1 = store, 0 = load.
REQ-006 ls_funct3  in  3  RV32 size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use 000/001/010).
REQ-007 ls_addr  in  32  byte address.
REQ-008 ls_wdata  in  32  store data, low bytes significant.
REQ-009 ls_busy  out  1  high in any state other than IDLE.
REQ-010 ls_done  out  1  one-cycle pulse at completion, success or error.
REQ-011 ls_err  out  1  qualifies ls_done: misalign, illegal funct3 or timeout.
REQ-012 ls_rdata  out  32  extended load data, the memory-read input of the writeback select.
REQ-013 mem_req  out  1  bus request, held until mem_ack.
REQ-014 mem_we  out  1  bus write enable.
REQ-015 mem_addr  out  32  word address, ls_addr with bits [1:0] forced to 0.
REQ-016 mem_be  out  4  byte enables.
REQ-017 mem_wdata  out  32  store data replicated onto selected lanes.
REQ-018 mem_ack  in  1  bus completion, valid only while mem_req high.
REQ-019 mem_rdata  in  32  read word, valid with mem_ack on loads.

Function
REQ-020 States IDLE, ACCESS, DONE; encoding free.
REQ-021 IDLE + ls_start: latch wr, funct3, addr, wdata, byte offset; check alignment and funct3 in the same cycle.
REQ-022 Misalignment: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; illegal funct3 (011, 110, 111; any of 1xx on stores).
REQ-023 Error on check: go to DONE with ls_err=1; no mem_req issued.
REQ-024 Valid request: go to ACCESS next cycle; mem_req=1 from first ACCESS cycle; mem_we, mem_addr, mem_be, mem_wdata stable while mem_req=1.
REQ-025 mem_be: byte = 0001<<off; half = 0011<<off; word = 1111; loads drive the same mask.
REQ-026 mem_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-027 ACCESS + mem_ack: capture mem_rdata, mem_req=0 next cycle, go to DONE.
REQ-028 Wait counter clears on ACCESS entry, increments each ACCESS cycle without mem_ack; reaching TIMEOUT goes to DONE with ls_err=1, ls_rdata unchanged.
REQ-029 mem_ack in the same cycle as timeout: ack wins, no error.
REQ-030 Load extraction: byte = rdata[8*off+7 : 8*off]; half = rdata[16*off[1]+15 : 16*off[1]]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-031 ls_rdata updates only on successful load completion and holds until the next one; stores and errors leave it unchanged.
REQ-032 DONE: ls_done=1 for exactly one cycle, then IDLE; ls_start ignored outside IDLE (no queuing).
REQ-033 Latency without error: ls_start at cycle 0, mem_req cycles 1..k where mem_ack arrives in cycle k, ls_done in cycle k+1; minimum 2 cycles start-to-done.
REQ-034 mem_ack outside ACCESS is ignored.

Reset
REQ-035 rst high on a clock edge: state IDLE, counter 0, ls_busy=0, ls_done=0, ls_err=0, ls_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
REQ-036 Reset mid-ACCESS drops mem_req the next cycle; no ls_done for the aborted request.
REQ-037 rst takes priority over ls_start and mem_ack in the same cycle.

Verification
REQ-038 LB, addr 0x103, mem_rdata 0x80FF_1234, ack after 2 wait cycles -> mem_addr 0x100, mem_be 1000, ls_rdata 0xFFFF_FF80, ls_done at cycle 4, ls_err 0.
REQ-039 LHU, addr 0x202, mem_rdata 0xBEEF_0000, immediate ack -> mem_be 1100, ls_rdata 0x0000_BEEF, ls_done at cycle 2.
REQ-040 SB, addr 0x301, wdata 0x0000_00A5 -> mem_we 1, mem_be 0010, mem_wdata 0xA5A5_A5A5, ls_rdata unchanged.
REQ-041 LW, addr 0x402 -> no mem_req, ls_done and ls_err pulse at cycle 1.
REQ-042 LW, mem_ack never asserted, TIMEOUT=15 -> mem_req held for 15 cycles, then ls_done with ls_err=1; ack in cycle 15 instead -> success.
REQ-043 rst asserted on the 3rd ACCESS cycle, then late mem_ack -> mem_req 0, no ls_done, all outputs at reset values, next ls_start accepted normally.
